// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlyline_prog.sv
// Programmable clocked delay line: delays a bus by 0..DEPTH enabled cycles.
// Provides a tap select, a synchronous flush and a validity flag for the selected tap.
module gf180mcu_fd_sc_mcu7t5v0__dlyline_prog #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SELW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             FLUSH,
    input  logic [SELW-1:0]  SEL,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Z,
    output logic             Z_VLD,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam logic [SELW-1:0] DEPTH_SEL = SELW'(DEPTH);

    logic [WIDTH-1:0] stage_q [1:DEPTH];
    logic [WIDTH-1:0] stage_d [1:DEPTH];
    logic [SELW-1:0]  fill_q;
    logic [SELW-1:0]  fill_d;
    logic [SELW-1:0]  tap_c;
    logic             unused_supply;

    // Supply pins carry no logic function.
    assign unused_supply = VDD ^ VSS;

    // Next-state: flush beats shift, otherwise hold.
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (FLUSH) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                stage_d[k] = '0;
            end
            fill_d = '0;
        end else if (EN) begin
            stage_d[1] = I;
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (fill_q != DEPTH_SEL) begin
                fill_d = fill_q + SELW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            fill_q <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
        end
    end

    // Clamped tap mux; I reaches Z only on tap 0.
    always_comb begin
        tap_c = (SEL > DEPTH_SEL) ? DEPTH_SEL : SEL;
        Z     = I;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            if (tap_c == SELW'(k)) begin
                Z = stage_q[k];
            end
        end
        Z_VLD = (fill_q >= tap_c);
    end

endmodule
